// File: rtl/analog_tx.sv
// Return path of the analog macro wrapper: pulses the read wordlines after a compute-finish
// edge, samples the macro spin outputs and offers them downstream over a valid/ready push.
module analog_tx #(
  parameter int NUM_SPIN         = 256,
  parameter int COUNTER_BITWIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic                        tx_configure_enable_i,
  input  logic [COUNTER_BITWIDTH-1:0] cycle_per_spin_read_i,
  input  logic [NUM_SPIN-1:0]         spin_rwl_strobe_i,
  input  logic                        analog_macro_cmpt_finish_i,
  input  logic [NUM_SPIN-1:0]         spin_analog_i,
  output logic [NUM_SPIN-1:0]         spin_rwl_o,
  output logic                        spin_push_valid_o,
  input  logic                        spin_push_ready_i,
  output logic [NUM_SPIN-1:0]         spin_push_o,
  output logic                        analog_tx_idle_o,
  output logic                        overrun_o
);

  // state | meaning
  // IDLE  | waiting for a compute-finish rising edge; config loads accepted
  // READ  | read wordlines driven, down-counter running to terminal count 1
  // VALID | sampled spin vector offered downstream, waiting for ready

  localparam int CW = COUNTER_BITWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cyc_q;
  logic [CW-1:0]       cnt_q;
  logic [NUM_SPIN-1:0] strobe_q;
  logic [NUM_SPIN-1:0] rwl_q;
  logic [NUM_SPIN-1:0] push_q;
  logic                finish_prev_q;
  logic                valid_q;
  logic                overrun_q;

  logic                finish_edge_d;
  logic [CW-1:0]       read_len_d;

  assign finish_edge_d = analog_macro_cmpt_finish_i & ~finish_prev_q;
  // A zero duration still gives a one-cycle read.
  assign read_len_d    = (cyc_q == '0) ? CW'(1) : cyc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q    <= '0;
      strobe_q <= '0;
    end else if (en_i && tx_configure_enable_i && (state_q == ST_IDLE)) begin
      cyc_q    <= cycle_per_spin_read_i;
      strobe_q <= spin_rwl_strobe_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      finish_prev_q <= 1'b0;
    end else begin
      finish_prev_q <= en_i ? analog_macro_cmpt_finish_i : 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rwl_q     <= '0;
      push_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!en_i) begin
      // Abort keeps the last pushed vector so downstream can still inspect it.
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rwl_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (finish_edge_d) begin
            state_q <= ST_READ;
            cnt_q   <= read_len_d;
            rwl_q   <= strobe_q;
          end
        end
        ST_READ: begin
          if (finish_edge_d) begin
            overrun_q <= 1'b1;
          end
          if (cnt_q == CW'(1)) begin
            push_q  <= spin_analog_i & strobe_q;
            rwl_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            state_q <= ST_VALID;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_VALID: begin
          if (finish_edge_d) begin
            overrun_q <= 1'b1;
          end
          if (valid_q && spin_push_ready_i) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          rwl_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign spin_rwl_o        = rwl_q;
  assign spin_push_valid_o = valid_q;
  assign spin_push_o       = push_q;
  assign overrun_o         = overrun_q;
  assign analog_tx_idle_o  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_analog_tx.sv
// Self-checking bench for analog_tx: expected spin vectors are queued when a read is
// launched and compared when the block presents them on the push interface.
module tb_analog_tx;

  localparam int NS = 256;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic          tx_configure_enable_i;
  logic [CW-1:0] cycle_per_spin_read_i;
  logic [NS-1:0] spin_rwl_strobe_i;
  logic          analog_macro_cmpt_finish_i;
  logic [NS-1:0] spin_analog_i;
  logic [NS-1:0] spin_rwl_o;
  logic          spin_push_valid_o;
  logic          spin_push_ready_i;
  logic [NS-1:0] spin_push_o;
  logic          analog_tx_idle_o;
  logic          overrun_o;

  analog_tx #(.NUM_SPIN(NS), .COUNTER_BITWIDTH(CW)) dut (
    .clk_i                      (clk_i),
    .rst_ni                     (rst_ni),
    .en_i                       (en_i),
    .tx_configure_enable_i      (tx_configure_enable_i),
    .cycle_per_spin_read_i      (cycle_per_spin_read_i),
    .spin_rwl_strobe_i          (spin_rwl_strobe_i),
    .analog_macro_cmpt_finish_i (analog_macro_cmpt_finish_i),
    .spin_analog_i              (spin_analog_i),
    .spin_rwl_o                 (spin_rwl_o),
    .spin_push_valid_o          (spin_push_valid_o),
    .spin_push_ready_i          (spin_push_ready_i),
    .spin_push_o                (spin_push_o),
    .analog_tx_idle_o           (analog_tx_idle_o),
    .overrun_o                  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  logic [NS-1:0] exp_q[$];
  logic [NS-1:0] last_exp;
  logic [NS-1:0] all1;
  logic [NS-1:0] mask0f;
  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [NS-1:0] obs, input logic [NS-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [NS-1:0] rnd_vec();
    logic [NS-1:0] v;
    for (int i = 0; i < NS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic cfg(input logic [CW-1:0] cyc, input logic [NS-1:0] strobe);
    tx_configure_enable_i = 1'b1;
    cycle_per_spin_read_i = cyc;
    spin_rwl_strobe_i     = strobe;
    tick();
    tx_configure_enable_i = 1'b0;
  endtask

  task automatic sb_check();
    chk("sb_nonempty", NS'(exp_q.size() != 0), NS'(1));
    if (exp_q.size() != 0) begin
      last_exp = exp_q.pop_front();
      chk("push_data", spin_push_o, last_exp);
    end
  endtask

  // Raise finish with a fixed spin pattern, check rwl for n cycles and valid afterwards.
  task automatic do_read(input int n, input logic [NS-1:0] strobe, input logic [NS-1:0] spin);
    spin_analog_i              = spin;
    analog_macro_cmpt_finish_i = 1'b1;
    exp_q.push_back(spin & strobe);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == 1) analog_macro_cmpt_finish_i = 1'b0;
      chk("rwl_on", spin_rwl_o, strobe);
      chk("busy", NS'(analog_tx_idle_o), NS'(0));
      chk("valid_low", NS'(spin_push_valid_o), NS'(0));
    end
    tick();
    chk("rwl_off", spin_rwl_o, '0);
    chk("valid_rise", NS'(spin_push_valid_o), NS'(1));
  endtask

  task automatic accept();
    spin_push_ready_i = 1'b1;
    sb_check();
    tick();
    spin_push_ready_i = 1'b0;
    chk("valid_fall", NS'(spin_push_valid_o), NS'(0));
    chk("idle_after", NS'(analog_tx_idle_o), NS'(1));
    chk("rwl_idle", spin_rwl_o, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_exp = '0;
    all1     = '1;
    mask0f   = {32{8'h0F}};
    rst_ni                     = 1'b0;
    en_i                       = 1'b0;
    tx_configure_enable_i      = 1'b0;
    cycle_per_spin_read_i      = '0;
    spin_rwl_strobe_i          = '0;
    analog_macro_cmpt_finish_i = 1'b0;
    spin_analog_i              = '0;
    spin_push_ready_i          = 1'b0;
    tick();
    tick();
    chk("rst_idle", NS'(analog_tx_idle_o), NS'(1));
    chk("rst_valid", NS'(spin_push_valid_o), NS'(0));
    chk("rst_rwl", spin_rwl_o, '0);
    chk("rst_push", spin_push_o, '0);
    chk("rst_overrun", NS'(overrun_o), NS'(0));
    rst_ni = 1'b1;
    en_i   = 1'b1;
    tick();

    // basic, three-cycle read
    cfg(8'd3, all1);
    do_read(3, all1, rnd_vec());
    accept();

    // zero duration behaves as one cycle
    cfg(8'd0, all1);
    do_read(1, all1, rnd_vec());
    accept();

    // backpressure: output held while the macro outputs keep changing
    cfg(8'd2, all1);
    do_read(2, all1, rnd_vec());
    for (int i = 0; i < 5; i++) begin
      spin_analog_i = rnd_vec();
      tick();
      chk("bp_valid", NS'(spin_push_valid_o), NS'(1));
      if (exp_q.size() != 0) chk("bp_stable", spin_push_o, exp_q[0]);
    end
    accept();

    // masking
    cfg(8'd2, mask0f);
    do_read(2, mask0f, all1);
    accept();

    // overrun during READ; config strobe in READ must be ignored
    cfg(8'd4, all1);
    spin_analog_i              = rnd_vec();
    analog_macro_cmpt_finish_i = 1'b1;
    exp_q.push_back(spin_analog_i);
    tick();
    analog_macro_cmpt_finish_i = 1'b0;
    chk("ovr_rwl1", spin_rwl_o, all1);
    tick();
    analog_macro_cmpt_finish_i = 1'b1;
    tx_configure_enable_i      = 1'b1;
    cycle_per_spin_read_i      = 8'd7;
    spin_rwl_strobe_i          = '0;
    chk("ovr_pre", NS'(overrun_o), NS'(0));
    tick();
    tx_configure_enable_i = 1'b0;
    chk("ovr_set", NS'(overrun_o), NS'(1));
    chk("ovr_rwl3", spin_rwl_o, all1);
    tick();
    chk("ovr_rwl4", spin_rwl_o, all1);
    tick();
    chk("ovr_rwl_off", spin_rwl_o, '0);
    chk("ovr_valid", NS'(spin_push_valid_o), NS'(1));
    accept();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ovr_no_second", NS'(analog_tx_idle_o), NS'(1));
      chk("ovr_no_rwl", spin_rwl_o, '0);
    end
    analog_macro_cmpt_finish_i = 1'b0;
    tick();
    chk("ovr_sticky", NS'(overrun_o), NS'(1));
    en_i = 1'b0;
    tick();
    chk("ovr_clear", NS'(overrun_o), NS'(0));
    en_i = 1'b1;
    tick();
    do_read(4, all1, rnd_vec());
    accept();

    // abort mid-READ
    spin_analog_i              = rnd_vec();
    analog_macro_cmpt_finish_i = 1'b1;
    tick();
    chk("ab_rwl_on", spin_rwl_o, all1);
    tick();
    en_i = 1'b0;
    tick();
    chk("ab_rwl", spin_rwl_o, '0);
    chk("ab_idle", NS'(analog_tx_idle_o), NS'(1));
    chk("ab_valid", NS'(spin_push_valid_o), NS'(0));
    chk("ab_push_kept", spin_push_o, last_exp);
    tick();
    chk("ab_held_idle", NS'(analog_tx_idle_o), NS'(1));
    analog_macro_cmpt_finish_i = 1'b0;
    en_i = 1'b1;
    tick();
    chk("ab_reen_idle", NS'(analog_tx_idle_o), NS'(1));
    tick();
    chk("ab_reen_rwl", spin_rwl_o, '0);
    do_read(4, all1, rnd_vec());
    accept();

    chk("sb_drained", NS'(exp_q.size()), NS'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
